// File: rtl/usb_write_pkg.sv
// Shared definitions for the FX2 slave-FIFO streaming writer.
package usb_write_pkg;

  // Writer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } state_t;

  // EP6 IN endpoint select on FIFOADR
  localparam logic [1:0] EP6_ADDR = 2'b10;

  // Words in one 512-byte high-speed packet
  localparam int EP_PKT_WORDS = 256;

  // Next value of the 16-bit test pattern (wraps FFFF -> 0000)
  function automatic logic [15:0] next_word(input logic [15:0] w);
    return w + 16'd1;
  endfunction

endpackage

// File: rtl/usb_write.sv
// Streaming writer for a Cypress FX2 slave FIFO in synchronous mode.
// Pushes an incrementing 16-bit pattern into the IN endpoint whenever the
// FIFO reports space, with a forced gap every BURST_LEN words.
// Optional build macro: USB_WRITE_FLAGA_GATE_EN -- when defined, FLAGA must
// also be high for a write to be issued; otherwise FLAGA is ignored.
module usb_write
  import usb_write_pkg::*;
#(
  parameter logic [1:0]  FIFO_ADDR = EP6_ADDR,
  parameter logic [15:0] DATA_INIT = 16'h0000,
  parameter int          BURST_LEN = EP_PKT_WORDS
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        FLAGD,
  input  logic        FLAGA,
  output logic        SLWR,
  output logic        SLRD,
  output logic        SLOE,
  output logic        IFCLK,
  output logic [1:0]  FIFOADR,
  output logic [15:0] FD
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BURST_MAX = BURST_LEN[BW-1:0];
  localparam logic [BW-1:0] BURST_ONE = {{(BW-1){1'b0}}, 1'b1};

  state_t        state_reg, state_next;
  logic          slwr_reg, slwr_next;
  logic [15:0]   fd_reg, fd_next;
  logic [15:0]   cnt_reg, cnt_next;    // next unsent pattern word
  logic [BW-1:0] burst_reg, burst_next; // words presented in current burst
  logic          ok;

`ifdef USB_WRITE_FLAGA_GATE_EN
  assign ok = FLAGD & FLAGA;
`else
  logic unused_flaga;
  assign unused_flaga = FLAGA;
  assign ok = FLAGD;
`endif

  // Fixed interface signals: read side idle, clock forwarded straight through
  assign SLRD    = 1'b1;
  assign SLOE    = 1'b1;
  assign IFCLK   = CLKOUT;
  assign FIFOADR = FIFO_ADDR;
  assign SLWR    = slwr_reg;
  assign FD      = fd_reg;

  // State and registered outputs; FD and SLWR come from the same stage
  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      slwr_reg  <= 1'b1;
      fd_reg    <= DATA_INIT;
      cnt_reg   <= DATA_INIT;
      burst_reg <= '0;
    end else begin
      state_reg <= state_next;
      slwr_reg  <= slwr_next;
      fd_reg    <= fd_next;
      cnt_reg   <= cnt_next;
      burst_reg <= burst_next;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_next = state_reg;
    slwr_next  = slwr_reg;
    fd_next    = fd_reg;
    cnt_next   = cnt_reg;
    burst_next = burst_reg;
    unique case (state_reg)
      IDLE: begin
        state_next = CHECK;
        slwr_next  = 1'b1;
      end
      CHECK: begin
        slwr_next = 1'b1;
        if (ok) begin
          // Present the next unsent word; it is accepted during that cycle
          state_next = WRITE;
          slwr_next  = 1'b0;
          fd_next    = cnt_reg;
          cnt_next   = next_word(cnt_reg);
          burst_next = burst_reg + BURST_ONE;
        end
      end
      WRITE: begin
        if (slwr_reg) begin
          // Burst gap cycle just went out; re-qualify in CHECK
          state_next = CHECK;
          slwr_next  = 1'b1;
        end else if (!ok) begin
          // Stall: FD holds, the boundary count still clears if reached
          state_next = CHECK;
          slwr_next  = 1'b1;
          if (burst_reg == BURST_MAX) begin
            burst_next = '0;
          end
        end else if (burst_reg == BURST_MAX) begin
          // Packet complete: one idle strobe cycle before CHECK
          slwr_next  = 1'b1;
          burst_next = '0;
        end else begin
          fd_next    = cnt_reg;
          cnt_next   = next_word(cnt_reg);
          burst_next = burst_reg + BURST_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        slwr_next  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_write.sv
// Directed self-checking bench for usb_write (default, short-burst and
// wrap-around instances share clock, reset and flags).
module tb_usb_write;

  logic clk;
  logic rst_n;
  logic flagd;
  logic flaga;

  logic        slwr_a, slrd_a, sloe_a, ifclk_a;
  logic [1:0]  adr_a;
  logic [15:0] fd_a;
  logic        slwr_b, slrd_b, sloe_b, ifclk_b;
  logic [1:0]  adr_b;
  logic [15:0] fd_b;
  logic        slwr_w, slrd_w, sloe_w, ifclk_w;
  logic [1:0]  adr_w;
  logic [15:0] fd_w;

  int n_cmp = 0;
  int n_err = 0;

  usb_write dut (
    .CLKOUT(clk), .rst_n(rst_n), .FLAGD(flagd), .FLAGA(flaga),
    .SLWR(slwr_a), .SLRD(slrd_a), .SLOE(sloe_a), .IFCLK(ifclk_a),
    .FIFOADR(adr_a), .FD(fd_a)
  );

  usb_write #(.BURST_LEN(4)) dut_b (
    .CLKOUT(clk), .rst_n(rst_n), .FLAGD(flagd), .FLAGA(flaga),
    .SLWR(slwr_b), .SLRD(slrd_b), .SLOE(sloe_b), .IFCLK(ifclk_b),
    .FIFOADR(adr_b), .FD(fd_b)
  );

  usb_write #(.DATA_INIT(16'hFFFE)) dut_w (
    .CLKOUT(clk), .rst_n(rst_n), .FLAGD(flagd), .FLAGA(flaga),
    .SLWR(slwr_w), .SLRD(slrd_w), .SLOE(sloe_w), .IFCLK(ifclk_w),
    .FIFOADR(adr_w), .FD(fd_w)
  );

  // 8 ns clock
  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed SLWR/FD after each edge following reset release, BURST_LEN=4
  logic        exp_slwr_b [14] = '{1,0,0,0,0,1,1,0,0,0,0,1,1,0};
  logic [15:0] exp_fd_b   [14] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3,
                                   16'd4, 16'd5, 16'd6, 16'd7, 16'd7, 16'd7, 16'd8};

  initial begin
    logic [15:0] exp_next;
    int          n_wr;
    int          exp_wr;

    // ---- reset state
    rst_n = 1'b0;
    flagd = 1'b1;
    flaga = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_slwr", {31'd0, slwr_a}, 32'd1);
    chk("rst_fd", {16'd0, fd_a}, 32'h0000);
    chk("rst_fd_w", {16'd0, fd_w}, 32'hFFFE);
    chk("rst_slrd", {31'd0, slrd_a}, 32'd1);
    chk("rst_sloe", {31'd0, sloe_a}, 32'd1);
    chk("rst_fifoadr", {30'd0, adr_a}, 32'd2);
    chk("ifclk_low", {31'd0, ifclk_a}, {31'd0, clk});

    // ---- continuous streaming after release
    rst_n = 1'b1;
    #1;
    chk("idle_slwr", {31'd0, slwr_a}, 32'd1);
    @(negedge clk);
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) @(negedge clk);
      chk("stream_slwr", {31'd0, slwr_a}, (n == 1) ? 32'd1 : 32'd0);
      chk("stream_fd", {16'd0, fd_a}, (n < 2) ? 32'd0 : n - 2);
      chk("burst_slwr", {31'd0, slwr_b}, {31'd0, exp_slwr_b[n-1]});
      chk("burst_fd", {16'd0, fd_b}, {16'd0, exp_fd_b[n-1]});
      chk("wrap_fd", {16'd0, fd_w}, (n < 2) ? 32'hFFFE : {16'd0, 16'(16'hFFFE + 16'(n - 2))});
      chk("const_slrd_sloe", {30'd0, slrd_a, sloe_a}, 32'd3);
      chk("const_fifoadr", {30'd0, adr_b}, 32'd2);
    end
    @(posedge clk);
    #1;
    chk("ifclk_high", {31'd0, ifclk_a}, 32'd1);

    // ---- asynchronous reset mid-burst, checked before the next edge
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_slwr", {29'd0, slwr_a, slwr_b, slwr_w}, 32'd7);
    chk("arst_fd", {16'd0, fd_a}, 32'h0000);
    chk("arst_fd_b", {16'd0, fd_b}, 32'h0000);
    chk("arst_fd_w", {16'd0, fd_w}, 32'hFFFE);
    chk("arst_const", {27'd0, slrd_a, sloe_a, adr_a, 1'b0}, 32'h1C);

    // ---- flag windows: FLAGD=1/FLAGA=0 2 cycles, FLAGD=0/FLAGA=1 10 cycles
    @(negedge clk);
    rst_n    = 1'b1;
    exp_next = 16'h0000;
    n_wr     = 0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int c = 0; c < 12; c++) begin
        flagd = (c < 2);
        flaga = !(c < 2);
        @(negedge clk);
        if (!flagd) chk("stall_slwr", {31'd0, slwr_a}, 32'd1);
        if (slwr_a === 1'b0) begin
          chk("win_seq_fd", {16'd0, fd_a}, {16'd0, exp_next});
          exp_next = exp_next + 16'd1;
          n_wr++;
        end else if (n_wr > 0) begin
          chk("win_hold_fd", {16'd0, fd_a}, {16'd0, 16'(exp_next - 16'd1)});
        end
      end
    end
`ifdef USB_WRITE_FLAGA_GATE_EN
    exp_wr = 0;
`else
    exp_wr = 9;
`endif
    chk("win_writes", n_wr, exp_wr);
    chk("win_final_fd", {16'd0, fd_a}, (exp_wr == 0) ? 32'd0 : exp_wr - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
